// File: rtl/esc_parser_pkg.sv
// esc_pkg: shared types and constants for the ANSI/VT100 escape-sequence parser.
// Optional SGR decoding is controlled by the ESC_SGR_EN macro (see esc_parser.sv).
package esc_pkg;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_ESC    = 2'd1,
    ST_CSI    = 2'd2
  } state_t;

  // Command opcodes presented on cmd with a cmdwr strobe
  localparam logic [2:0] CMD_CUP = 3'd0;
  localparam logic [2:0] CMD_CUU = 3'd1;
  localparam logic [2:0] CMD_CUD = 3'd2;
  localparam logic [2:0] CMD_CUF = 3'd3;
  localparam logic [2:0] CMD_CUB = 3'd4;
  localparam logic [2:0] CMD_ED  = 3'd5;
  localparam logic [2:0] CMD_EL  = 3'd6;
  localparam logic [2:0] CMD_SGR = 3'd7;

  // Protocol bytes
  localparam logic [7:0] CH_ESC  = 8'h1B;
  localparam logic [7:0] CH_CSI  = 8'h5B;
  localparam logic [7:0] CH_CAN  = 8'h18;
  localparam logic [7:0] CH_SUB  = 8'h1A;
  localparam logic [7:0] CH_SEMI = 8'h3B;

  // Byte class bounds inside a CSI sequence
  localparam logic [7:0] CH_C0_HI       = 8'h1F;
  localparam logic [7:0] CH_DIG_LO      = 8'h30;
  localparam logic [7:0] CH_DIG_HI      = 8'h39;
  localparam logic [7:0] CH_INTERM_LO   = 8'h20;
  localparam logic [7:0] CH_INTERM_HI   = 8'h3F;
  localparam logic [7:0] CH_FINAL_LO    = 8'h40;
  localparam logic [7:0] CH_FINAL_HI    = 8'h7E;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_DIG_LO) && (b <= CH_DIG_HI);
  endfunction

  function automatic logic is_final(input logic [7:0] b);
    return (b >= CH_FINAL_LO) && (b <= CH_FINAL_HI);
  endfunction

endpackage

// File: rtl/esc_parser_if.sv
// Byte-in / character-and-command-out bus of the escape-sequence parser.
// master: the serial receiver side plus downstream consumers; slave: the parser.
interface esc_parser_if
  import esc_pkg::*;
#(
  parameter int PARAM_W = 7
);
  logic               inwr;
  logic [7:0]         indata;
  logic               outwr;
  logic [7:0]         outdata;
  logic               cmdwr;
  logic [2:0]         cmd;
  logic [PARAM_W-1:0] arg0;
  logic [PARAM_W-1:0] arg1;

  modport master (
    output inwr, indata,
    input  outwr, outdata, cmdwr, cmd, arg0, arg1
  );

  modport slave (
    input  inwr, indata,
    output outwr, outdata, cmdwr, cmd, arg0, arg1
  );
endinterface

// File: rtl/esc_parser_param_acc.sv
// esc_param_acc: one decimal CSI parameter accumulator, saturating at 2^PARAM_W-1.
module esc_param_acc #(
  parameter int PARAM_W = 7
) (
  input  logic               clk25,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               dig_vld_i,
  input  logic [3:0]         dig_i,
  output logic [PARAM_W-1:0] val_o,
  output logic               present_o
);
  // Four extra bits hold max*10+9 without wrapping
  localparam int SUM_W = PARAM_W + 4;
  localparam logic [SUM_W-1:0] SAT = SUM_W'((1 << PARAM_W) - 1);

  logic [PARAM_W-1:0] val_q;
  logic               present_q;
  logic [SUM_W-1:0]   sum;

  assign sum = SUM_W'(val_q) * SUM_W'(10) + SUM_W'(dig_i);

  // Accumulate digits; clear at the start of every CSI sequence
  always_ff @(posedge clk25) begin
    if (rst || clr_i) begin
      val_q     <= '0;
      present_q <= 1'b0;
    end else if (dig_vld_i) begin
      val_q     <= (sum > SAT) ? PARAM_W'(SAT) : PARAM_W'(sum);
      present_q <= 1'b1;
    end
  end

  assign val_o     = val_q;
  assign present_o = present_q;
endmodule

// File: rtl/esc_parser.sv
// esc_parser: ANSI/VT100 escape-sequence parser. Plain bytes pass through on
// outwr/outdata; CSI sequences become single-cycle cmdwr strobes with args.
// Define ESC_SGR_EN to decode final 'm' as SGR; otherwise it is swallowed.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_GROUND | normal text, bytes passed through
//   ST_ESC    | ESC seen, waiting for '[' to open a CSI sequence
//   ST_CSI    | collecting parameters until a final byte
module esc_parser
  import esc_pkg::*;
#(
  parameter int MAXPARAM = 2,
  parameter int PARAM_W  = 7
) (
  input logic        clk25,
  input logic        rst,
  esc_parser_if.slave bus
);
  localparam int IDX_W  = (MAXPARAM > 1) ? $clog2(MAXPARAM) : 1;
  localparam int P1_IDX = (MAXPARAM > 1) ? 1 : 0;

  state_t             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               ovf_q;
  logic               priv_q;
  logic               outwr_q;
  logic               cmdwr_q;
  logic [7:0]         outdata_q;
  logic [2:0]         cmd_q;
  logic [PARAM_W-1:0] arg0_q;
  logic [PARAM_W-1:0] arg1_q;

  logic [PARAM_W-1:0] pval [MAXPARAM];
  logic               pres [MAXPARAM];
  logic               acc_clr;
  logic               dig_any;

  logic               dec_vld;
  logic [2:0]         dec_cmd;
  logic [PARAM_W-1:0] dec_arg0;
  logic [PARAM_W-1:0] dec_arg1;
  logic [PARAM_W-1:0] p0;
  logic [PARAM_W-1:0] p1;
  logic               p0_pres;
  logic               p1_pres;

  // Params are wiped when '[' opens a sequence, not on exit, so args stay stable
  assign acc_clr = bus.inwr && (state_q == ST_ESC) && (bus.indata == CH_CSI);
  // Digits after the last parameter slot overflowed are dropped
  assign dig_any = bus.inwr && (state_q == ST_CSI) && is_digit(bus.indata) && !ovf_q;

  for (genvar i = 0; i < MAXPARAM; i++) begin : g_acc
    esc_param_acc #(.PARAM_W(PARAM_W)) u_acc (
      .clk25     (clk25),
      .rst       (rst),
      .clr_i     (acc_clr),
      .dig_vld_i (dig_any && (idx_q == IDX_W'(i))),
      .dig_i     (bus.indata[3:0]),
      .val_o     (pval[i]),
      .present_o (pres[i])
    );
  end

  assign p0      = pval[0];
  assign p0_pres = pres[0];
  assign p1      = (MAXPARAM > 1) ? pval[P1_IDX] : '0;
  assign p1_pres = (MAXPARAM > 1) ? pres[P1_IDX] : 1'b0;

  // Absent or zero parameter defaults to 1 for cursor commands
  function automatic logic [PARAM_W-1:0] def1(input logic present,
                                             input logic [PARAM_W-1:0] v);
    return (present && (v != '0)) ? v : PARAM_W'(1);
  endfunction

  // Decode the current byte as a final byte against the collected params
  always_comb begin
    dec_vld  = 1'b0;
    dec_cmd  = CMD_CUP;
    dec_arg0 = '0;
    dec_arg1 = '0;
    case (bus.indata)
      8'h48, 8'h66: begin
        dec_vld  = 1'b1;
        dec_cmd  = CMD_CUP;
        dec_arg0 = def1(p0_pres, p0);
        dec_arg1 = def1(p1_pres, p1);
      end
      8'h41: begin dec_vld = 1'b1; dec_cmd = CMD_CUU; dec_arg0 = def1(p0_pres, p0); end
      8'h42: begin dec_vld = 1'b1; dec_cmd = CMD_CUD; dec_arg0 = def1(p0_pres, p0); end
      8'h43: begin dec_vld = 1'b1; dec_cmd = CMD_CUF; dec_arg0 = def1(p0_pres, p0); end
      8'h44: begin dec_vld = 1'b1; dec_cmd = CMD_CUB; dec_arg0 = def1(p0_pres, p0); end
      8'h4A: begin dec_vld = 1'b1; dec_cmd = CMD_ED;  dec_arg0 = p0_pres ? p0 : '0; end
      8'h4B: begin dec_vld = 1'b1; dec_cmd = CMD_EL;  dec_arg0 = p0_pres ? p0 : '0; end
`ifdef ESC_SGR_EN
      8'h6D: begin dec_vld = 1'b1; dec_cmd = CMD_SGR; dec_arg0 = p0_pres ? p0 : '0; end
`endif
      default: ;
    endcase
  end

  // Sequencing FSM with registered strobes and held data/args
  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q   <= ST_GROUND;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
      priv_q    <= 1'b0;
      outwr_q   <= 1'b0;
      cmdwr_q   <= 1'b0;
      outdata_q <= '0;
      cmd_q     <= '0;
      arg0_q    <= '0;
      arg1_q    <= '0;
    end else begin
      outwr_q <= 1'b0;
      cmdwr_q <= 1'b0;
      if (bus.inwr) begin
        case (state_q)
          ST_GROUND: begin
            if (bus.indata == CH_ESC) begin
              state_q <= ST_ESC;
            end else begin
              outwr_q   <= 1'b1;
              outdata_q <= bus.indata;
            end
          end
          ST_ESC: begin
            if (bus.indata == CH_CSI) begin
              state_q <= ST_CSI;
              idx_q   <= '0;
              ovf_q   <= 1'b0;
              priv_q  <= 1'b0;
            end else if (bus.indata != CH_ESC) begin
              state_q <= ST_GROUND;
            end
          end
          ST_CSI: begin
            if (is_digit(bus.indata)) begin
              // accumulated by the param slices
            end else if (bus.indata == CH_SEMI) begin
              if (idx_q == IDX_W'(MAXPARAM - 1)) ovf_q <= 1'b1;
              else                               idx_q <= idx_q + IDX_W'(1);
            end else if ((bus.indata >= CH_INTERM_LO) && (bus.indata <= CH_INTERM_HI)) begin
              priv_q <= 1'b1;
            end else if (is_final(bus.indata)) begin
              state_q <= ST_GROUND;
              if (dec_vld && !priv_q) begin
                cmdwr_q <= 1'b1;
                cmd_q   <= dec_cmd;
                arg0_q  <= dec_arg0;
                arg1_q  <= dec_arg1;
              end
            end else if ((bus.indata == CH_CAN) || (bus.indata == CH_SUB)) begin
              state_q <= ST_GROUND;
            end else if (bus.indata == CH_ESC) begin
              state_q <= ST_ESC;
            end else if (bus.indata <= CH_C0_HI) begin
              outwr_q   <= 1'b1;
              outdata_q <= bus.indata;
            end
          end
          default: state_q <= ST_GROUND;
        endcase
      end
    end
  end

  assign bus.outwr   = outwr_q;
  assign bus.outdata = outdata_q;
  assign bus.cmdwr   = cmdwr_q;
  assign bus.cmd     = cmd_q;
  assign bus.arg0    = arg0_q;
  assign bus.arg1    = arg1_q;
endmodule

// File: tb/tb_esc_parser.sv
// Directed bench for esc_parser: byte sequences in, logged strobes compared
// against hand-computed event lists (byte position, kind, payload).
module tb_esc_parser;
  import esc_pkg::*;

  logic clk25 = 1'b0;
  logic rst   = 1'b1;

  esc_parser_if #(.PARAM_W(7)) bus ();

  esc_parser #(.MAXPARAM(2), .PARAM_W(7)) dut (
    .clk25 (clk25),
    .rst   (rst),
    .bus   (bus)
  );

  always #20 clk25 = ~clk25;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  seq_q [$];
  logic [47:0] exp_q [$];
  logic [47:0] got_q [$];

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // event word: {byte position, kind, outdata, cmd, arg0, arg1}
  function automatic logic [47:0] ev_out(input int k, input logic [7:0] b);
    return {8'(k), 8'h01, b, 24'h0};
  endfunction

  function automatic logic [47:0] ev_cmd(input int k, input logic [2:0] c,
                                         input logic [6:0] a0, input logic [6:0] a1);
    return {8'(k), 8'h02, 8'h00, 5'b0, c, 1'b0, a0, 1'b0, a1};
  endfunction

  task automatic capture(input int k);
    check("excl", {47'b0, bus.outwr & bus.cmdwr}, 48'h0);
    if (bus.outwr) got_q.push_back(ev_out(k, bus.outdata));
    if (bus.cmdwr) got_q.push_back(ev_cmd(k, bus.cmd, bus.arg0, bus.arg1));
  endtask

  task automatic run_seq(input string tag);
    got_q.delete();
    foreach (seq_q[k]) begin
      @(negedge clk25);
      bus.inwr   = 1'b1;
      bus.indata = seq_q[k];
      @(posedge clk25);
      #1;
      capture(k);
    end
    @(negedge clk25);
    bus.inwr   = 1'b0;
    bus.indata = 8'h00;
    @(posedge clk25);
    #1;
    capture(seq_q.size());
    check({tag, ":count"}, 48'(got_q.size()), 48'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check(tag, got_q[i], exp_q[i]);
    exp_q.delete();
  endtask

  initial begin
    bus.inwr   = 1'b0;
    bus.indata = 8'h00;
    rst        = 1'b1;
    repeat (3) @(posedge clk25);
    #1;
    check("rst_outwr", {47'b0, bus.outwr}, 48'h0);
    check("rst_cmdwr", {47'b0, bus.cmdwr}, 48'h0);
    check("rst_data",  {24'b0, bus.outdata, 5'b0, bus.cmd, 1'b0, bus.arg0}, 48'h0);
    check("rst_arg1",  {41'b0, bus.arg1}, 48'h0);
    @(negedge clk25);
    rst = 1'b0;

    seq_q = '{8'h41, 8'h1B, 8'h5B, 8'h31, 8'h32, 8'h3B, 8'h34, 8'h30, 8'h48};
    exp_q.push_back(ev_out(0, 8'h41));
    exp_q.push_back(ev_cmd(8, CMD_CUP, 7'd12, 7'd40));
    run_seq("cup_12_40");
    check("hold_cmd", {40'b0, 5'b0, bus.cmd}, {40'b0, 5'b0, CMD_CUP});
    check("hold_arg", {34'b0, bus.arg0, bus.arg1}, {34'b0, 7'd12, 7'd40});
    check("hold_outdata", {40'b0, bus.outdata}, 48'h41);

    seq_q = '{8'h1B, 8'h5B, 8'h41};
    exp_q.push_back(ev_cmd(2, CMD_CUU, 7'd1, 7'd0));
    run_seq("cuu_absent");

    seq_q = '{8'h1B, 8'h5B, 8'h30, 8'h43};
    exp_q.push_back(ev_cmd(3, CMD_CUF, 7'd1, 7'd0));
    run_seq("cuf_zero");

    seq_q = '{8'h1B, 8'h5B, 8'h32, 8'h4A};
    exp_q.push_back(ev_cmd(3, CMD_ED, 7'd2, 7'd0));
    run_seq("ed_2");

    seq_q = '{8'h1B, 8'h5B, 8'h39, 8'h39, 8'h39, 8'h42};
    exp_q.push_back(ev_cmd(5, CMD_CUD, 7'd127, 7'd0));
    run_seq("cud_sat");

    seq_q = '{8'h1B, 8'h5B, 8'h31, 8'h3B, 8'h32, 8'h3B, 8'h33, 8'h48};
    exp_q.push_back(ev_cmd(7, CMD_CUP, 7'd1, 7'd2));
    run_seq("cup_extra_param");

    seq_q = '{8'h1B, 8'h5B, 8'h31, 8'h18, 8'h58};
    exp_q.push_back(ev_out(4, 8'h58));
    run_seq("can_abort");

    seq_q = '{8'h1B, 8'h5B, 8'h3F, 8'h32, 8'h35, 8'h68};
    run_seq("private");

    seq_q = '{8'h1B, 8'h5B, 8'h31, 8'h0A, 8'h41};
    exp_q.push_back(ev_out(3, 8'h0A));
    exp_q.push_back(ev_cmd(4, CMD_CUU, 7'd1, 7'd0));
    run_seq("c0_in_csi");

    seq_q = '{8'h1B, 8'h5B, 8'h33, 8'h31, 8'h6D};
`ifdef ESC_SGR_EN
    exp_q.push_back(ev_cmd(4, CMD_SGR, 7'd31, 7'd0));
`endif
    run_seq("sgr");

    seq_q = '{8'h1B, 8'h5B, 8'h48};
    exp_q.push_back(ev_cmd(2, CMD_CUP, 7'd1, 7'd1));
    run_seq("cup_default");

    seq_q = '{8'h1B, 8'h5B, 8'h4A};
    exp_q.push_back(ev_cmd(2, CMD_ED, 7'd0, 7'd0));
    run_seq("ed_absent");

    seq_q = '{8'h1B, 8'h5B, 8'h37, 8'h4B};
    exp_q.push_back(ev_cmd(3, CMD_EL, 7'd7, 7'd0));
    run_seq("el_7");

    seq_q = '{8'h1B, 8'h1B, 8'h5B, 8'h41};
    exp_q.push_back(ev_cmd(3, CMD_CUU, 7'd1, 7'd0));
    run_seq("esc_esc");

    seq_q = '{8'h1B, 8'h58, 8'h41};
    exp_q.push_back(ev_out(2, 8'h41));
    run_seq("esc_discard");

    seq_q = '{8'h1B, 8'h5B, 8'h7F, 8'h35, 8'h44};
    exp_q.push_back(ev_cmd(4, CMD_CUB, 7'd5, 7'd0));
    run_seq("del_ignored");

    seq_q = '{8'h1B, 8'h5B, 8'h5A};
    run_seq("unknown_final");

    seq_q = '{8'h1B, 8'h5B, 8'h33, 8'h3B, 8'h34, 8'h66};
    exp_q.push_back(ev_cmd(5, CMD_CUP, 7'd3, 7'd4));
    run_seq("cup_f");

    seq_q = '{8'h1B, 8'h5B, 8'h31, 8'h1B, 8'h5B, 8'h32, 8'h41};
    exp_q.push_back(ev_cmd(6, CMD_CUU, 7'd2, 7'd0));
    run_seq("restart_esc");

    // reset mid-sequence; the 'B' presented with reset must not emit CUD
    seq_q = '{8'h1B, 8'h5B, 8'h35};
    run_seq("pre_rst");
    @(negedge clk25);
    rst        = 1'b1;
    bus.inwr   = 1'b1;
    bus.indata = 8'h42;
    @(posedge clk25);
    #1;
    check("rst_suppress", {46'b0, bus.outwr, bus.cmdwr}, 48'h0);
    @(negedge clk25);
    rst        = 1'b0;
    bus.inwr   = 1'b0;
    bus.indata = 8'h00;

    seq_q = '{8'h41};
    exp_q.push_back(ev_out(0, 8'h41));
    run_seq("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
